mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory request/response port between the I-cache (read-only) and the D-cache (read/write) on a cache miss.
- D-cache has fixed priority.
- A saturating starvation counter forces an I-cache grant after MAX_WAIT consecutive lost arbitrations.
- Sits between both caches and the memory model; one transaction is outstanding at a time.

Parameters:
- ADDR_W, 28, memory request address width (16-byte line address).
- DATA_W, 128, memory data width; mask width is DATA_W/8.
- MAX_WAIT, 4, D-cache wins tolerated before the I-cache is forced to win; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ic_req_valid  in  1  I-cache read request.
- ic_req_addr  in  ADDR_W  I-cache line address.
- ic_req_ready  out  1  I-cache request accepted this cycle.
- ic_resp_valid  out  1  I-cache read data valid.
- ic_resp_data  out  DATA_W  I-cache read data.
- dc_req_valid  in  1  D-cache request.
- dc_req_rw  in  1  D-cache direction: 1 = write, 0 = read.
- dc_req_addr  in  ADDR_W  D-cache line address.
- dc_req_data  in  DATA_W  D-cache write data.
- dc_req_mask  in  DATA_W/8  D-cache byte write mask.
- dc_req_ready  out  1  D-cache request accepted this cycle.
- dc_resp_valid  out  1  D-cache read data valid.
- dc_resp_data  out  DATA_W  D-cache read data.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_rw  out  1  memory request direction: 1 = write, 0 = read.
- mem_req_addr  out  ADDR_W  memory address.
- mem_req_data  out  DATA_W  memory write data.
- mem_req_mask  out  DATA_W/8  memory byte write mask.
- mem_resp_valid  in  1  memory read data valid.
- mem_resp_data  in  DATA_W  memory read data.
- ic_wait_cnt  out  4  current starvation count (debug).

Behaviour:
- Reset (async, any state):
  - state = IDLE, owner = DC, ic_wait_cnt = 0.
  - All valid/ready outputs are 0 immediately; any in-flight transaction is abandoned.
- Requester handshake:
  - A requester holds its valid and payload stable until it sees its ready.
  - Request-path muxing is combinational from the owner register; no payload is registered.
- IDLE:
  - No requests: stay in IDLE.
  - Only one requester valid: it wins.
  - Both valid: D-cache wins unless ic_wait_cnt == MAX_WAIT, in which case the I-cache wins.
  - Winner is latched into owner; next state is ISSUE.
  - Arbitration costs 1 cycle; mem_req_valid is never asserted in IDLE.
- ISSUE:
  - mem_req_valid = 1; mem_req_* driven from the owner's payload.
  - For an I-cache owner: mem_req_rw = 0, mem_req_data = 0, mem_req_mask = 0.
  - The owner's req_ready = mem_req_ready, so the accept happens in the same cycle as the memory handshake.
  - On the handshake: write goes to IDLE (no response expected); read goes to WAIT_RESP.
  - mem_req_ready low: stay in ISSUE indefinitely.
- WAIT_RESP:
  - On mem_resp_valid: the owner's resp_valid = 1 for exactly that cycle, then IDLE.
  - ic_resp_data and dc_resp_data both equal mem_resp_data at all times; only the valids are gated.
- mem_resp_valid outside WAIT_RESP is ignored; both resp_valid outputs stay 0.
- Starvation counter (saturating, 4 bits):
  - Updated only on an IDLE arbitration decision.
  - D-cache wins while ic_req_valid = 1: increment, holding at MAX_WAIT.
  - I-cache wins: clear to 0.
  - Otherwise: hold.
- Requester drops valid while not owner: no effect; the arbiter has no knowledge of the request.
- Back-to-back transactions: minimum 3 cycles per read (IDLE, ISSUE, WAIT_RESP) and 2 cycles per write.

Optional Feature:
- MEM_ARB_PERF_EN defined:
  - Adds outputs perf_ic_grants, perf_dc_grants and perf_conflicts, each 32 bits and wrapping.
  - Each grant counter increments on an IDLE decision for that requester.
  - perf_conflicts increments on an IDLE decision with both valids high.
  - All three clear on reset.
- MEM_ARB_PERF_EN undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- I-cache read only (addr 0x0000100), memory ready after 2 cycles, response 0xDEADBEEF... 2 cycles later -> one ic_req_ready pulse, one ic_resp_valid pulse carrying that data, dc_resp_valid stays 0, ic_wait_cnt stays 0.
- D-cache write (addr 0x0000200, mask 0xFFFF) -> mem_req_rw = 1 with matching data/mask, dc_req_ready pulse, return to IDLE with no response wait, next grant decided 1 cycle later.
- Both requesters continuously valid, MAX_WAIT = 4, memory always ready, 1-cycle response -> grant order DC, DC, DC, DC, IC, DC...; ic_wait_cnt goes 1, 2, 3, 4, 0.
- Stray mem_resp_valid while in IDLE and while in ISSUE -> no resp_valid on either cache; FSM unaffected.
- Reset asserted in WAIT_RESP, then released -> mem_req_valid/ready/resp_valid outputs 0 asynchronously, ic_wait_cnt = 0, next request arbitrated normally from IDLE.
- With MEM_ARB_PERF_EN, 3 conflicts resolved DC, DC, DC plus 1 lone I-cache request -> perf_dc_grants = 3, perf_ic_grants = 1, perf_conflicts = 3.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I-cache/D-cache main-memory arbiter; optional perf counters under MEM_ARB_PERF_EN
module mem_arbiter #(
  parameter int ADDR_W   = 28,
  parameter int DATA_W   = 128,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_req_valid,
  input  logic [ADDR_W-1:0]     ic_req_addr,
  output logic                  ic_req_ready,
  output logic                  ic_resp_valid,
  output logic [DATA_W-1:0]     ic_resp_data,
  input  logic                  dc_req_valid,
  input  logic                  dc_req_rw,
  input  logic [ADDR_W-1:0]     dc_req_addr,
  input  logic [DATA_W-1:0]     dc_req_data,
  input  logic [DATA_W/8-1:0]   dc_req_mask,
  output logic                  dc_req_ready,
  output logic                  dc_resp_valid,
  output logic [DATA_W-1:0]     dc_resp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rw,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_data,
  output logic [DATA_W/8-1:0]   mem_req_mask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_data,
  output logic [3:0]            ic_wait_cnt
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_ic_grants,
  output logic [31:0]           perf_dc_grants,
  output logic [31:0]           perf_conflicts
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;
  typedef enum logic {OWN_DC, OWN_IC} owner_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state, state_nxt;
  owner_t     owner, owner_nxt;
  logic [3:0] wait_nxt;
  logic       grant_ic;
  logic       decide;

  // Read data fans out to both caches; only the valids are steered
  assign ic_resp_data = mem_resp_data;
  assign dc_resp_data = mem_resp_data;

  // IDLE arbitration: D-cache has priority unless the I-cache has lost MAX_WAIT times in a row
  always_comb begin
    grant_ic = ic_req_valid && (!dc_req_valid || ic_wait_cnt == MAX_WAIT_C);
    decide   = (state == IDLE) && (ic_req_valid || dc_req_valid);
  end

  // Next state, owner, starvation count and the owner-muxed request/response handshakes
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    wait_nxt      = ic_wait_cnt;
    mem_req_valid = 1'b0;
    ic_req_ready  = 1'b0;
    dc_req_ready  = 1'b0;
    ic_resp_valid = 1'b0;
    dc_resp_valid = 1'b0;
    if (owner == OWN_IC) begin
      mem_req_rw   = 1'b0;
      mem_req_addr = ic_req_addr;
      mem_req_data = '0;
      mem_req_mask = '0;
    end else begin
      mem_req_rw   = dc_req_rw;
      mem_req_addr = dc_req_addr;
      mem_req_data = dc_req_data;
      mem_req_mask = dc_req_mask;
    end
    case (state)
      IDLE: begin
        if (decide) begin
          state_nxt = ISSUE;
          owner_nxt = grant_ic ? OWN_IC : OWN_DC;
          if (grant_ic)
            wait_nxt = 4'd0;
          else if (ic_req_valid && ic_wait_cnt != MAX_WAIT_C)
            wait_nxt = ic_wait_cnt + 4'd1;
        end
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (owner == OWN_IC) ic_req_ready = mem_req_ready;
        else                 dc_req_ready = mem_req_ready;
        if (mem_req_ready)
          state_nxt = mem_req_rw ? IDLE : WAIT_RESP;
      end
      WAIT_RESP: begin
        if (mem_resp_valid) begin
          if (owner == OWN_IC) ic_resp_valid = 1'b1;
          else                 dc_resp_valid = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, owner and starvation count; reset abandons any in-flight transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_DC;
      ic_wait_cnt <= 4'd0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      ic_wait_cnt <= wait_nxt;
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Wrapping grant and conflict counters, stepped on each IDLE decision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_ic_grants <= '0;
      perf_dc_grants <= '0;
      perf_conflicts <= '0;
    end else if (decide) begin
      if (grant_ic) perf_ic_grants <= perf_ic_grants + 32'd1;
      else          perf_dc_grants <= perf_dc_grants + 32'd1;
      if (ic_req_valid && dc_req_valid) perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 28, DW = 128, MW = 16, MAXW = 4;

  logic clk = 1'b0, reset;
  logic ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [AW-1:0] ic_req_addr;
  logic [DW-1:0] ic_resp_data;
  logic dc_req_valid, dc_req_rw, dc_req_ready, dc_resp_valid;
  logic [AW-1:0] dc_req_addr;
  logic [DW-1:0] dc_req_data, dc_resp_data;
  logic [MW-1:0] dc_req_mask;
  logic mem_req_valid, mem_req_ready, mem_req_rw, mem_resp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data, mem_resp_data;
  logic [MW-1:0] mem_req_mask;
  logic [3:0] ic_wait_cnt;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_ic_grants, perf_dc_grants, perf_conflicts;
`endif

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_mask(dc_req_mask), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .ic_wait_cnt(ic_wait_cnt)
`ifdef MEM_ARB_PERF_EN
    , .perf_ic_grants(perf_ic_grants), .perf_dc_grants(perf_dc_grants), .perf_conflicts(perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [DW-1:0] ic_q[$], dc_q[$];
  logic [DW-1:0] smem[logic [AW-1:0]];
  logic [DW-1:0] rmem[logic [AW-1:0]];
  logic grants[$];
  int rdy_pct = 100, lat_min = 0, lat_max = 0, stray_en = 0;
  int n_ic = 0, n_dc = 0, n_conf = 0;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  function automatic logic [DW-1:0] pat(logic [AW-1:0] a);
    return {4{a, 4'hA}};
  endfunction

  function automatic logic [DW-1:0] srd(logic [AW-1:0] a);
    return smem.exists(a) ? smem[a] : pat(a);
  endfunction

  function automatic logic [DW-1:0] rrd(logic [AW-1:0] a);
    return rmem.exists(a) ? rmem[a] : pat(a);
  endfunction

  // Memory model: random ready, random read latency, stray responses while no read is pending
  initial begin : slave
    logic hs, hrw, pend;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd, v, pdata;
    logic [MW-1:0] hm;
    int cd;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; pend = 1'b0; cd = 0;
    forever begin
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready;
      hrw = mem_req_rw; ha = mem_req_addr; hd = mem_req_data; hm = mem_req_mask;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (reset) begin
        pend = 1'b0;
        mem_req_ready = 1'b0;
      end else begin
        if (hs) begin
          if (hrw) begin
            v = srd(ha);
            for (int b = 0; b < MW; b++) if (hm[b]) v[b*8 +: 8] = hd[b*8 +: 8];
            smem[ha] = v;
          end else begin
            pend = 1'b1; pdata = srd(ha); cd = $urandom_range(lat_max, lat_min);
          end
        end
        if (pend) begin
          if (cd == 0) begin
            mem_resp_valid = 1'b1; mem_resp_data = pdata; pend = 1'b0;
          end else cd--;
        end else if (stray_en != 0 && $urandom_range(3, 0) == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
        end
        mem_req_ready = ($urandom_range(99, 0) < rdy_pct);
      end
    end
  end

  // Monitor: reference arbitration, request-path payload and response scoreboard
  initial begin : monitor
    logic prev_mv, prev_icv, prev_dcv, win_ic;
    int m_cnt;
    prev_mv = 0; prev_icv = 0; prev_dcv = 0; win_ic = 0; m_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_mv = 0; prev_icv = 0; prev_dcv = 0; win_ic = 0; m_cnt = 0;
        n_ic = 0; n_dc = 0; n_conf = 0;
        grants.delete();
      end else begin
        if (mem_req_valid && !prev_mv) begin
          if (!prev_icv && !prev_dcv) timeout("spurious_grant");
          win_ic = prev_icv && (!prev_dcv || m_cnt == MAXW);
          if (win_ic) m_cnt = 0;
          else if (prev_icv && m_cnt < MAXW) m_cnt++;
          if (win_ic) n_ic++; else n_dc++;
          if (prev_icv && prev_dcv) n_conf++;
          grants.push_back(win_ic);
          chk("wait_cnt", ic_wait_cnt, m_cnt);
        end
        if (mem_req_valid) begin
          if (win_ic) begin
            chk("ic_addr", mem_req_addr, ic_req_addr);
            chk("ic_rw_data_mask", {mem_req_rw, mem_req_data, mem_req_mask}, '0);
          end else begin
            chk("dc_addr", mem_req_addr, dc_req_addr);
            chk("dc_payload", {mem_req_rw, mem_req_data, mem_req_mask}, {dc_req_rw, dc_req_data, dc_req_mask});
          end
          chk("ic_req_ready", ic_req_ready, win_ic && mem_req_ready);
          chk("dc_req_ready", dc_req_ready, !win_ic && mem_req_ready);
        end else begin
          chk("ready_idle", {ic_req_ready, dc_req_ready}, 2'b00);
        end
        chk("resp_data_fanout", {ic_resp_data, dc_resp_data}, {mem_resp_data, mem_resp_data});
        if (ic_resp_valid && dc_resp_valid) timeout("both_resp_valid");
        if (ic_resp_valid) begin
          if (ic_q.size() == 0) chk("ic_resp_unexpected", 1, 0);
          else chk("ic_resp_data", ic_resp_data, ic_q.pop_front());
        end
        if (dc_resp_valid) begin
          if (dc_q.size() == 0) chk("dc_resp_unexpected", 1, 0);
          else chk("dc_resp_data", dc_resp_data, dc_q.pop_front());
        end
        prev_mv = mem_req_valid; prev_icv = ic_req_valid; prev_dcv = dc_req_valid;
      end
    end
  end

  task automatic ic_run(int n, int gap_max);
    int t;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      ic_req_addr = (i == 0) ? 28'h0000100 : 28'h0000100 + 28'($urandom_range(15, 0));
      ic_q.push_back(pat(ic_req_addr));
      ic_req_valid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!ic_req_ready && t < 300);
      if (!ic_req_ready) timeout("ic_ready_timeout");
      @(posedge clk); #1;
      ic_req_valid = 1'b0;
      repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic dc_run(int n, int gap_max);
    int t;
    logic [DW-1:0] v;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      dc_req_addr = (i == 0) ? 28'h0000200 : 28'h0000200 + 28'($urandom_range(15, 0));
      dc_req_rw = 1'($urandom_range(1, 0));
      dc_req_data = {$urandom, $urandom, $urandom, $urandom};
      dc_req_mask = ($urandom_range(3, 0) == 0) ? 16'hFFFF : 16'($urandom);
      if (dc_req_rw) begin
        v = rrd(dc_req_addr);
        for (int b = 0; b < MW; b++) if (dc_req_mask[b]) v[b*8 +: 8] = dc_req_data[b*8 +: 8];
        rmem[dc_req_addr] = v;
      end else dc_q.push_back(rrd(dc_req_addr));
      dc_req_valid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!dc_req_ready && t < 300);
      if (!dc_req_ready) timeout("dc_ready_timeout");
      @(posedge clk); #1;
      dc_req_valid = 1'b0;
      repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain(string name);
    int t = 0;
    while ((ic_q.size() != 0 || dc_q.size() != 0) && t < 500) begin @(negedge clk); t++; end
    chk(name, ic_q.size() + dc_q.size(), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    ic_q.delete(); dc_q.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin : main
    logic exp_g[5];
    int t;
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ic_req_valid = 0; ic_req_addr = '0;
    dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0; dc_req_data = '0; dc_req_mask = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #11;
    chk("reset_valids", {mem_req_valid, ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid}, '0);
    chk("reset_wait_cnt", ic_wait_cnt, 0);
    @(posedge clk); #1 reset = 1'b0;

    // lone I-cache read
    rdy_pct = 40; lat_min = 2; lat_max = 2; stray_en = 0;
    ic_run(1, 0);
    drain("ic_only_drain");
    chk("ic_only_wait_cnt", ic_wait_cnt, 0);

    // randomized traffic with stray responses
    rdy_pct = 60; lat_min = 0; lat_max = 3; stray_en = 1;
    fork
      ic_run(40, 3);
      dc_run(40, 3);
    join
    drain("random_drain");

    // continuous conflict: starvation forcing
    pulse_reset();
    rdy_pct = 100; lat_min = 0; lat_max = 0; stray_en = 0;
    fork
      ic_run(3, 0);
      dc_run(14, 0);
    join
    drain("starve_drain");
    chk("starve_grant_count_ge5", grants.size() >= 5, 1);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk($sformatf("starve_grant%0d_is_ic", i), grants[i], exp_g[i]);

    // reset while waiting on a D-cache read, with the I-cache starving
    pulse_reset();
    lat_min = 10; lat_max = 10;
    @(posedge clk); #1;
    ic_req_valid = 1; ic_req_addr = 28'h0000100;
    dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h0000200;
    t = 0;
    do begin @(negedge clk); t++; end while (!dc_req_ready && t < 50);
    chk("rst_pre_dc_ready", dc_req_ready, 1);
    @(posedge clk); #1 dc_req_valid = 0;
    @(negedge clk);
    chk("rst_pre_wait_cnt", ic_wait_cnt, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_outputs", {mem_req_valid, ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid}, '0);
    chk("rst_async_wait_cnt", ic_wait_cnt, 0);
    ic_req_valid = 0;
    ic_q.delete(); dc_q.delete();
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    lat_min = 0; lat_max = 2; rdy_pct = 70;
    fork
      ic_run(3, 1);
      dc_run(3, 1);
    join
    drain("post_reset_drain");

`ifdef MEM_ARB_PERF_EN
    chk("perf_ic_grants", perf_ic_grants, n_ic);
    chk("perf_dc_grants", perf_dc_grants, n_dc);
    chk("perf_conflicts", perf_conflicts, n_conf);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
